// File: rtl/ipu_frame_sequencer.sv
// Frame-level controller for the IPU: arms on CPU command, gates camera pixel-valid for one
// frame per sample (with optional decimation) and holds the first detected coordinate in a mailbox.
`timescale 1ns/1ps
module ipu_frame_sequencer #(
    parameter int FRAME_W   = 640,
    parameter int FRAME_H   = 480,
    parameter int DRAIN_CYC = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [10:0] iX_Cont,
    input  logic [10:0] iY_Cont,
    input  logic        iStart,
    input  logic        iStop,
    input  logic        iContinuous,
    input  logic [3:0]  iSkip,
    input  logic        iAck,
    input  logic [10:0] iIPU_Row,
    input  logic [10:0] iIPU_Col,
    input  logic        iIPU_VALID,
    output logic        oIPU_DVAL,
    output logic        oCoordValid,
    output logic [10:0] oRow,
    output logic [10:0] oCol,
    output logic        oMiss,
    output logic [7:0]  oFrameCnt,
    output logic        oBusy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SKIP   = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_REPORT = 3'd5;
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    logic [2:0]    r_state;
    logic [3:0]    r_skip;
    logic [3:0]    r_skipcnt;
    logic          r_cont;
    logic          r_cap;
    logic [10:0]   r_cap_row;
    logic [10:0]   r_cap_col;
    logic [DW-1:0] r_drain;

    logic          w_sof;
    logic          w_eof;
    logic [2:0]    w_nstate;
    logic          w_enter_rpt;
    logic          w_rpt_miss;
    logic [10:0]   w_rpt_row;
    logic [10:0]   w_rpt_col;

    assign w_sof = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
    assign w_eof = iDVAL && (iX_Cont == 11'(FRAME_W - 1)) && (iY_Cont == 11'(FRAME_H - 1));

    // A SOF seen while running means the camera restarted; it closes the old frame and is not passed.
    assign oIPU_DVAL = iDVAL && (((r_state == S_RUN) && !w_sof) || ((r_state == S_ARM) && w_sof));
    assign oBusy     = (r_state != S_IDLE);

    always_comb begin
        w_nstate    = r_state;
        w_enter_rpt = 1'b0;
        w_rpt_miss  = 1'b0;
        w_rpt_row   = r_cap ? r_cap_row : iIPU_Row;
        w_rpt_col   = r_cap ? r_cap_col : iIPU_Col;
        case (r_state)
            S_IDLE:  if (iStart) w_nstate = S_SKIP;
            S_SKIP:  if (r_skipcnt == 4'd0) w_nstate = S_ARM;
            S_ARM:   if (w_sof) w_nstate = S_RUN;
            S_RUN: begin
                if (w_eof || w_sof) begin
                    if (r_cap || iIPU_VALID) begin
                        w_nstate    = S_REPORT;
                        w_enter_rpt = 1'b1;
                    end else begin
                        w_nstate = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (iIPU_VALID) begin
                    w_nstate    = S_REPORT;
                    w_enter_rpt = 1'b1;
                end else if (r_drain == DW'(DRAIN_CYC - 1)) begin
                    w_nstate    = S_REPORT;
                    w_enter_rpt = 1'b1;
                    w_rpt_miss  = 1'b1;
                    w_rpt_row   = 11'h7FF;
                    w_rpt_col   = 11'h7FF;
                end
            end
            S_REPORT: if (iAck) w_nstate = r_cont ? S_SKIP : S_IDLE;
            default:  w_nstate = S_IDLE;
        endcase
        if (iStop) begin
            w_nstate    = S_IDLE;
            w_enter_rpt = 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state     <= S_IDLE;
            r_skip      <= 4'd0;
            r_skipcnt   <= 4'd0;
            r_cont      <= 1'b0;
            r_cap       <= 1'b0;
            r_cap_row   <= 11'd0;
            r_cap_col   <= 11'd0;
            r_drain     <= '0;
            oCoordValid <= 1'b0;
            oRow        <= 11'd0;
            oCol        <= 11'd0;
            oMiss       <= 1'b0;
            oFrameCnt   <= 8'd0;
        end else begin
            r_state <= w_nstate;
            r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;

            if (!iStop) begin
                if (r_state == S_IDLE && iStart) begin
                    r_skip    <= iSkip;
                    r_cont    <= iContinuous;
                    r_skipcnt <= iSkip;
                end else if (r_state == S_SKIP && r_skipcnt != 4'd0 && w_sof) begin
                    r_skipcnt <= r_skipcnt - 4'd1;
                end else if (r_state == S_REPORT && iAck) begin
                    r_skipcnt <= r_skip;
                end
            end

            // Only the first coordinate of a sampled frame is kept.
            if (r_state == S_ARM && w_sof)
                r_cap <= 1'b0;
            else if (r_state == S_RUN && iIPU_VALID && !r_cap) begin
                r_cap     <= 1'b1;
                r_cap_row <= iIPU_Row;
                r_cap_col <= iIPU_Col;
            end

            if (w_enter_rpt) begin
                oCoordValid <= 1'b1;
                oRow        <= w_rpt_row;
                oCol        <= w_rpt_col;
                oMiss       <= w_rpt_miss;
                oFrameCnt   <= oFrameCnt + 8'd1;
            end else if (iStop || (r_state == S_REPORT && iAck)) begin
                oCoordValid <= 1'b0;
                oMiss       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ipu_frame_sequencer.sv
// Directed bench for ipu_frame_sequencer on a small 8x4 frame; mailbox reports are checked
// against a queue of expected results filled as each sampled frame is driven.
`timescale 1ns/1ps
module tb_ipu_frame_sequencer;
    localparam int FW = 8;
    localparam int FH = 4;
    localparam int DC = 64;
    localparam int NPIX = FW * FH;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iDVAL;
    logic [10:0] iX_Cont;
    logic [10:0] iY_Cont;
    logic        iStart;
    logic        iStop;
    logic        iContinuous;
    logic [3:0]  iSkip;
    logic        iAck;
    logic [10:0] iIPU_Row;
    logic [10:0] iIPU_Col;
    logic        iIPU_VALID;
    logic        oIPU_DVAL;
    logic        oCoordValid;
    logic [10:0] oRow;
    logic [10:0] oCol;
    logic        oMiss;
    logic [7:0]  oFrameCnt;
    logic        oBusy;

    always #5 iCLK = ~iCLK;

    ipu_frame_sequencer #(.FRAME_W(FW), .FRAME_H(FH), .DRAIN_CYC(DC)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .iStart(iStart), .iStop(iStop), .iContinuous(iContinuous), .iSkip(iSkip), .iAck(iAck),
        .iIPU_Row(iIPU_Row), .iIPU_Col(iIPU_Col), .iIPU_VALID(iIPU_VALID),
        .oIPU_DVAL(oIPU_DVAL), .oCoordValid(oCoordValid), .oRow(oRow), .oCol(oCol),
        .oMiss(oMiss), .oFrameCnt(oFrameCnt), .oBusy(oBusy)
    );

    typedef struct packed {
        logic [10:0] row;
        logic [10:0] col;
        logic        miss;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] exp_cnt = 8'd0;
    logic       prev_cv = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int r, input int c, input logic m);
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{row: 11'(r), col: 11'(c), miss: m, cnt: exp_cnt});
    endtask

    // Scoreboard: each new mailbox report is matched against the oldest expectation.
    always @(negedge iCLK) begin
        if (oCoordValid && !prev_cv) begin
            chk("sb_expected_present", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_row",  32'(oRow),      32'(e.row));
                chk("sb_col",  32'(oCol),      32'(e.col));
                chk("sb_miss", 32'(oMiss),     32'(e.miss));
                chk("sb_cnt",  32'(oFrameCnt), 32'(e.cnt));
            end
        end
        prev_cv <= oCoordValid;
    end

    task automatic tick;
        @(posedge iCLK); #1;
    endtask

    task automatic pix(input logic dv, input int x, input int y, input logic iv,
                       input int r, input int c, output logic g);
        @(posedge iCLK); #1;
        iDVAL = dv; iX_Cont = 11'(x); iY_Cont = 11'(y);
        iIPU_VALID = iv; iIPU_Row = 11'(r); iIPU_Col = 11'(c);
        @(negedge iCLK);
        g = oIPU_DVAL;
    endtask

    // Drives npix pixels in raster order; IPU valid at pixel v1 (r1,c1) and at v2 (0x55,0x66).
    task automatic frame(input int v1, input int r1, input int c1, input int v2,
                         input int npix, output int gated);
        logic g;
        gated = 0;
        for (int i = 0; i < npix; i++) begin
            pix(1'b1, i % FW, i / FW, (i == v1) || (i == v2),
                (i == v2) ? 'h55 : r1, (i == v2) ? 'h66 : c1, g);
            if (g) gated++;
        end
        @(posedge iCLK); #1;
        iDVAL = 1'b0; iIPU_VALID = 1'b0;
    endtask

    task automatic wait_rpt(output int cyc);
        cyc = 0;
        @(negedge iCLK);
        while (!oCoordValid && cyc < 300) begin
            @(negedge iCLK);
            cyc++;
        end
        chk("report_seen", 32'(oCoordValid), 32'd1);
    endtask

    task automatic ack;
        iAck = 1'b1; tick; iAck = 1'b0; tick; tick;
    endtask

    task automatic start(input logic [3:0] skip, input logic cont);
        iStart = 1'b1; iSkip = skip; iContinuous = cont;
        tick;
        iStart = 1'b0;
        tick; tick;
    endtask

    task automatic do_reset;
        iRST = 1'b1; tick; tick; iRST = 1'b0; tick;
        exp_cnt = 8'd0;
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gated;
        int   cyc;
        logic g;

        iRST = 1'b1; iDVAL = 1'b1; iX_Cont = '0; iY_Cont = '0; iStart = 1'b0; iStop = 1'b0;
        iContinuous = 1'b0; iSkip = '0; iAck = 1'b0; iIPU_Row = '0; iIPU_Col = '0; iIPU_VALID = 1'b0;
        tick; tick;
        chk("rst_dval",  32'(oIPU_DVAL),   32'd0);
        chk("rst_cv",    32'(oCoordValid), 32'd0);
        chk("rst_row",   32'(oRow),        32'd0);
        chk("rst_col",   32'(oCol),        32'd0);
        chk("rst_miss",  32'(oMiss),       32'd0);
        chk("rst_cnt",   32'(oFrameCnt),   32'd0);
        chk("rst_busy",  32'(oBusy),       32'd0);
        iDVAL = 1'b0; iRST = 1'b0; tick;

        // Not armed: nothing gated, IPU valid ignored
        frame(5, 1, 1, -1, NPIX, gated);
        chk("idle_gated", gated, 0);
        chk("idle_cv", 32'(oCoordValid), 32'd0);

        // 1: single shot, coordinate mid-frame
        start(4'd0, 1'b0);
        pix(1'b1, 3, 2, 1'b0, 0, 0, g);
        chk("arm_nonsof_gate", 32'(g), 32'd0);
        push_exp(120, 300, 1'b0);
        frame(13, 120, 300, -1, NPIX, gated);
        chk("t1_gated", gated, NPIX);
        wait_rpt(cyc);
        chk("t1_latency", cyc, 0);
        chk("t1_busy_rpt", 32'(oBusy), 32'd1);
        ack;
        chk("t1_cv_after_ack", 32'(oCoordValid), 32'd0);
        chk("t1_busy_after_ack", 32'(oBusy), 32'd0);
        chk("t1_cnt", 32'(oFrameCnt), 32'd1);

        // 2: skip=2 continuous, frames 3/6/9 sampled; second IPU valid in a frame dropped
        do_reset;
        start(4'd2, 1'b1);
        for (int f = 1; f <= 9; f++) begin
            if (f % 3 == 0) push_exp(f, 10 * f, 1'b0);
            frame(4, f, 10 * f, 20, NPIX, gated);
            chk("t2_gated", gated, (f % 3 == 0) ? NPIX : 0);
            if (f % 3 == 0) begin
                wait_rpt(cyc);
                ack;
                chk("t2_cnt", 32'(oFrameCnt), f / 3);
            end else begin
                chk("t2_no_report", 32'(oCoordValid), 32'd0);
            end
        end
        iStop = 1'b1; tick; iStop = 1'b0;
        chk("t2_stop_busy", 32'(oBusy), 32'd0);

        // 3: no detection -> miss after exactly DC drain cycles; stop in REPORT
        do_reset;
        start(4'd0, 1'b0);
        push_exp('h7FF, 'h7FF, 1'b1);
        frame(-1, 0, 0, -1, NPIX, gated);
        wait_rpt(cyc);
        chk("t3_drain_latency", cyc, DC);
        iStop = 1'b1; tick; iStop = 1'b0;
        chk("t3_stop_cv",   32'(oCoordValid), 32'd0);
        chk("t3_stop_miss", 32'(oMiss),       32'd0);
        chk("t3_stop_cnt",  32'(oFrameCnt),   32'd1);
        chk("t3_stop_busy", 32'(oBusy),       32'd0);

        // 4: late coordinate captured during drain; follow-up valid ignored
        start(4'd0, 1'b0);
        push_exp(55, 66, 1'b0);
        frame(-1, 0, 0, -1, NPIX, gated);
        repeat (9) tick;
        chk("t4_in_drain", 32'(oCoordValid), 32'd0);
        iIPU_VALID = 1'b1; iIPU_Row = 11'd55; iIPU_Col = 11'd66;
        tick;
        iIPU_Row = 11'd77; iIPU_Col = 11'd88;
        tick;
        iIPU_VALID = 1'b0;
        tick;
        wait_rpt(cyc);
        chk("t4_row_held", 32'(oRow), 32'd55);
        chk("t4_col_held", 32'(oCol), 32'd66);
        ack;

        // Camera restart: new SOF in RUN closes the frame and is not gated
        start(4'd0, 1'b0);
        push_exp(9, 9, 1'b0);
        gated = 0;
        for (int i = 0; i < 12; i++) begin
            pix(1'b1, i % FW, i / FW, i == 5, 9, 9, g);
            if (g) gated++;
        end
        chk("restart_gated", gated, 12);
        pix(1'b1, 0, 0, 1'b0, 0, 0, g);
        chk("restart_sof_gate", 32'(g), 32'd0);
        tick; iDVAL = 1'b0;
        wait_rpt(cyc);
        chk("restart_latency", cyc, 0);
        ack;

        // 5: stop during RUN; start+stop together stays idle
        start(4'd0, 1'b0);
        for (int i = 0; i < 6; i++) pix(1'b1, i, 0, 1'b0, 0, 0, g);
        @(posedge iCLK); #1; iStop = 1'b1; iX_Cont = 11'd6;
        @(posedge iCLK); #1; iStop = 1'b0; iX_Cont = 11'd7;
        @(negedge iCLK);
        chk("t5_stop_dval", 32'(oIPU_DVAL), 32'd0);
        chk("t5_stop_busy", 32'(oBusy), 32'd0);
        iDVAL = 1'b0;
        iStart = 1'b1; iStop = 1'b1; tick; iStart = 1'b0; iStop = 1'b0; tick;
        chk("t5_start_stop", 32'(oBusy), 32'd0);
        chk("t5_cnt_held", 32'(oFrameCnt), 32'd3);

        // 6: asynchronous reset mid-RUN
        start(4'd0, 1'b0);
        for (int i = 0; i < 6; i++) pix(1'b1, i, 0, 1'b0, 0, 0, g);
        chk("t6_pre_dval", 32'(g), 32'd1);
        #2 iRST = 1'b1;
        #1;
        chk("t6_rst_dval", 32'(oIPU_DVAL), 32'd0);
        chk("t6_rst_busy", 32'(oBusy), 32'd0);
        chk("t6_rst_cnt",  32'(oFrameCnt), 32'd0);
        iDVAL = 1'b0;
        tick; iRST = 1'b0; tick;
        exp_cnt = 8'd0;
        sb.delete();

        // 256 continuous reports wrap the frame counter
        start(4'd0, 1'b1);
        for (int k = 0; k < 256; k++) begin
            push_exp(k, k + 1, 1'b0);
            frame(3, k, k + 1, -1, NPIX, gated);
            wait_rpt(cyc);
            ack;
        end
        chk("t6_wrap_cnt", 32'(oFrameCnt), 32'd0);
        iStop = 1'b1; tick; iStop = 1'b0; tick;

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
